// File: rtl/bram_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_burst_arbiter
// Purpose  : Round-robin arbiter and burst sequencer that shares one BRAM port
//            between two clients. A granted burst issues one access per cycle
//            at base+0 .. base+len-1. Read data returns through a registered
//            valid strobe. A one-cycle done pulse, with err qualifying a
//            rejected request, reports completion.
// Ports    : clk, rst                 clock and synchronous active-high reset
//            cN_req_i/we_i/addr_i/len_i  burst request from client N
//            cN_wdata_i               write word, consumed while cN_wstb_o is high
//            cN_gnt_o/wstb_o/rvalid_o/done_o  per-client handshake strobes
//            rdata_o, err_o           shared read data and rejection flag
//            mem_*                    BRAM port (addr, ce, we, d, q)
//            idle_o, run_o            state status
// Revision : 1.0  initial release
// ============================================================================
module bram_burst_arbiter #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 7,
  parameter int MEM_SIZE = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req_i,
  input  logic              c0_we_i,
  input  logic [AWIDTH-1:0] c0_addr_i,
  input  logic [AWIDTH-1:0] c0_len_i,
  input  logic [DWIDTH-1:0] c0_wdata_i,
  output logic              c0_gnt_o,
  output logic              c0_wstb_o,
  output logic              c0_rvalid_o,
  output logic              c0_done_o,
  input  logic              c1_req_i,
  input  logic              c1_we_i,
  input  logic [AWIDTH-1:0] c1_addr_i,
  input  logic [AWIDTH-1:0] c1_len_i,
  input  logic [DWIDTH-1:0] c1_wdata_i,
  output logic              c1_gnt_o,
  output logic              c1_wstb_o,
  output logic              c1_rvalid_o,
  output logic              c1_done_o,
  output logic [DWIDTH-1:0] rdata_o,
  output logic              err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [DWIDTH-1:0] mem_d_o,
  input  logic [DWIDTH-1:0] mem_q_i,
  output logic              idle_o,
  output logic              run_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // End address of a burst is compared one bit wider than the address so
  // base + len can never wrap around.
  localparam logic [AWIDTH:0] MEM_LIMIT = (AWIDTH+1)'(MEM_SIZE);

  state_t            state;
  state_t            state_nxt;

  logic [AWIDTH-1:0] cnt;
  logic [AWIDTH-1:0] base;
  logic [AWIDTH-1:0] len;
  logic              we_lat;
  logic              owner;
  logic              err_lat;
  logic              last_gnt;
  logic              c0_rvalid_q;
  logic              c1_rvalid_q;

  logic              any_req;
  logic              win;
  logic [AWIDTH-1:0] sel_addr;
  logic [AWIDTH-1:0] sel_len;
  logic              sel_we;
  logic [AWIDTH:0]   sel_end;
  logic              sel_rej;
  logic              last_access;

  // Winner selection: a lone requester wins; on a tie the client that was
  // not granted last time wins.
  always_comb begin
    any_req  = c0_req_i | c1_req_i;
    if (c0_req_i && c1_req_i) begin
      win = ~last_gnt;
    end else begin
      win = c1_req_i;
    end
    sel_addr = win ? c1_addr_i : c0_addr_i;
    sel_len  = win ? c1_len_i  : c0_len_i;
    sel_we   = win ? c1_we_i   : c0_we_i;
    sel_end  = {1'b0, sel_addr} + {1'b0, sel_len};
    sel_rej  = (sel_len == '0) || (sel_end > MEM_LIMIT);
  end

  assign last_access = (cnt == (len - AWIDTH'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    c0_gnt_o   = 1'b0;
    c1_gnt_o   = 1'b0;
    c0_wstb_o  = 1'b0;
    c1_wstb_o  = 1'b0;
    c0_done_o  = 1'b0;
    c1_done_o  = 1'b0;
    err_o      = 1'b0;
    mem_ce_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_d_o    = '0;
    unique case (state)
      S_IDLE: begin
        if (any_req) begin
          c0_gnt_o  = ~win;
          c1_gnt_o  = win;
          state_nxt = sel_rej ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        mem_ce_o   = 1'b1;
        mem_we_o   = we_lat;
        mem_addr_o = base + cnt;
        if (we_lat) begin
          // Owner supplies the word combinationally against its wstb.
          mem_d_o   = owner ? c1_wdata_i : c0_wdata_i;
          c0_wstb_o = ~owner;
          c1_wstb_o = owner;
        end
        if (last_access) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        c0_done_o = ~owner;
        c1_done_o = owner;
        err_o     = err_lat;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      base        <= '0;
      len         <= '0;
      we_lat      <= 1'b0;
      owner       <= 1'b0;
      err_lat     <= 1'b0;
      last_gnt    <= 1'b1;
      c0_rvalid_q <= 1'b0;
      c1_rvalid_q <= 1'b0;
    end else begin
      // BRAM read latency is one cycle, so the strobe simply trails the access.
      c0_rvalid_q <= mem_ce_o & ~mem_we_o & ~owner;
      c1_rvalid_q <= mem_ce_o & ~mem_we_o & owner;
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            base    <= sel_addr;
            len     <= sel_len;
            we_lat  <= sel_we;
            owner   <= win;
            err_lat <= sel_rej;
            cnt     <= '0;
          end
        end
        S_RUN: begin
          cnt <= cnt + AWIDTH'(1);
        end
        S_DONE: begin
          last_gnt <= owner;
          cnt      <= '0;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign c0_rvalid_o = c0_rvalid_q;
  assign c1_rvalid_o = c1_rvalid_q;
  assign rdata_o     = mem_q_i;
  assign idle_o      = (state == S_IDLE);
  assign run_o       = (state == S_RUN);

endmodule
`default_nettype wire
